// File: rtl/puf_response_uart_tx.sv
// puf_response_uart_tx: sends the latched 8-bit PUF response to the host as a
// single asynchronous serial frame: start bit, 8 data bits LSB first,
// optional even-parity bit, then STOP_BITS stop bits. At most one frame is
// sent per reset epoch.
// Build option: define PUF_UART_PARITY_EN to add a parity bit after the data
// bits. Without the macro the frame is plain 8N1/8N2.
module puf_response_uart_tx #(
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1          // 1 or 2
) (
  input  logic       clock,
  input  logic       computer_ack_reset,
  input  logic       ready_to_read,
  input  logic [7:0] resp_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       response_sent
);

  // Integer division; the bit period must be at least 2 clocks.
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PUF_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             rdy_q;
  logic             tx_q;
  logic             tx_busy_q;
  logic             tx_done_q;
  logic             sent_q;
`ifdef PUF_UART_PARITY_EN
  logic             parity_q;
`endif

  logic cnt_last;
  logic trigger;

  // Bit boundary and rising-edge trigger; only a fresh edge in IDLE starts a
  // frame, and never once the response has already gone out.
  assign cnt_last = (baud_cnt_q == CNT_LAST);
  assign trigger  = ready_to_read & ~rdy_q & (state_q == IDLE) & ~sent_q;

  // Frame sequencer with all line-facing outputs registered (glitch-free tx).
  always_ff @(posedge clock or posedge computer_ack_reset) begin
    if (computer_ack_reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rdy_q      <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      sent_q     <= 1'b0;
`ifdef PUF_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      rdy_q     <= ready_to_read;
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          tx_q       <= 1'b1;
          tx_busy_q  <= 1'b0;
          if (trigger) begin
            // Latch the byte now so later buffer changes cannot corrupt it.
            shift_q   <= resp_data;
`ifdef PUF_UART_PARITY_EN
            parity_q  <= ^resp_data;
`endif
            state_q   <= START;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_last) begin
            baud_cnt_q <= '0;
            state_q    <= DATA;
            tx_q       <= shift_q[0];
            shift_q    <= shift_q >> 1;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef PUF_UART_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`ifdef PUF_UART_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            baud_cnt_q <= '0;
            state_q    <= STOP;
            tx_q       <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // bit_idx_q is reused to count stop-bit periods.
          if (cnt_last) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= '0;
              state_q   <= DONE;
              tx_busy_q <= 1'b0;
              tx_done_q <= 1'b1;
              sent_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          baud_cnt_q <= '0;
          tx_q       <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx            = tx_q;
  assign tx_busy       = tx_busy_q;
  assign tx_done       = tx_done_q;
  assign response_sent = sent_q;

endmodule

// File: tb/tb_puf_response_uart_tx.sv
// Bench for puf_response_uart_tx: CLKS_PER_BIT = 10. Instance 0 uses one
// stop bit, instance 1 uses two. Expected line levels come from a frame model
// built as a list of bit levels; parity expectations follow PUF_UART_PARITY_EN.
module tb_puf_response_uart_tx;

  localparam int CPB = 10;
`ifdef PUF_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [2];
  logic       rdy    [2];
  logic [7:0] data   [2];
  logic       tx_w   [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       sent_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  puf_response_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .STOP_BITS(1)) dut0 (
    .clock(clk), .computer_ack_reset(rst[0]), .ready_to_read(rdy[0]),
    .resp_data(data[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .tx_done(done_w[0]), .response_sent(sent_w[0]));

  puf_response_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .STOP_BITS(2)) dut1 (
    .clock(clk), .computer_ack_reset(rst[1]), .ready_to_read(rdy[1]),
    .resp_data(data[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .tx_done(done_w[1]), .response_sent(sent_w[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reset one instance for two cycles and check the reset outputs.
  task automatic apply_reset(input int i);
    @(negedge clk);
    rst[i] = 1'b1;
    rdy[i] = 1'b0;
    @(negedge clk);
    check($sformatf("reset outputs dut%0d", i),
          32'({tx_w[i], busy_w[i], done_w[i], sent_w[i]}), 32'(4'b1000));
    @(negedge clk);
    rst[i] = 1'b0;
  endtask

  // Raise ready_to_read (called at a negedge) and follow one whole frame.
  task automatic run_frame(input int i, input logic [7:0] b, input int nstop,
                           input bit pulse, input int change_at,
                           input int exp_done, input string tag);
    bit q[$];
    int f, done_at, busy_bad;
    q.push_back(1'b0);
    for (int j = 0; j < 8; j++) q.push_back(b[j]);
    if (PAR == 1) q.push_back(^b);
    for (int s = 0; s < nstop; s++) q.push_back(1'b1);
    f = q.size() * CPB;
    data[i] = b;
    rdy[i]  = 1'b1;
    done_at = -1;
    busy_bad = 0;
    for (int k = 1; k <= f + 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1)
        check($sformatf("%s tx low after trigger", tag), 32'(tx_w[i]), 32'(0));
      if (k <= f && (k % CPB) == CPB / 2)
        check($sformatf("%s bit%0d", tag, (k - 1) / CPB), 32'(tx_w[i]), 32'(q[(k - 1) / CPB]));
      if (done_w[i] === 1'b1 && done_at < 0) done_at = k;
      if (busy_w[i] !== (k <= f)) busy_bad++;
      if (pulse && k == 1) rdy[i] = 1'b0;
      if (k == change_at) data[i] = ~b;
    end
    check($sformatf("%s tx_done cycle", tag), 32'(done_at), 32'(exp_done));
    check($sformatf("%s busy window errors", tag), 32'(busy_bad), 32'(0));
    check($sformatf("%s response_sent", tag), 32'(sent_w[i]), 32'(1));
    check($sformatf("%s tx idle after", tag), 32'(tx_w[i]), 32'(1));
  endtask

  // After a frame: retoggle ready_to_read and change data; nothing may happen.
  task automatic idle_check(input int i, input int n, input string tag);
    int bad = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0) bad++;
      if ((k % 7) == 0) begin
        rdy[i]  = ~rdy[i];
        data[i] = 8'($urandom);
      end
    end
    check($sformatf("%s no second frame", tag), 32'(bad), 32'(0));
  endtask

  typedef struct {
    logic [7:0] b;
    bit         pulse;
    int         change_at;
    int         exp_done;
  } vec_t;

  vec_t tbl[5];

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    data[0] = 8'h00; data[1] = 8'h00;

    tbl[0] = '{b: 8'hA5, pulse: 1'b0, change_at: 0, exp_done: 101 + 10 * PAR};
    tbl[1] = '{b: 8'hFF, pulse: 1'b1, change_at: 5, exp_done: 101 + 10 * PAR};
    tbl[2] = '{b: 8'h07, pulse: 1'b0, change_at: 0, exp_done: 101 + 10 * PAR};
    tbl[3] = '{b: 8'h03, pulse: 1'b0, change_at: 0, exp_done: 101 + 10 * PAR};
    tbl[4] = '{b: 8'h3C, pulse: 1'b0, change_at: 30, exp_done: 101 + 10 * PAR};

    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      apply_reset(0);
      run_frame(0, tbl[v].b, 1, tbl[v].pulse, tbl[v].change_at, tbl[v].exp_done,
                $sformatf("vec%0d", v));
      idle_check(0, 60, $sformatf("vec%0d", v));
    end

    // Abort mid-frame, then restart with ready_to_read already high.
    apply_reset(0);
    data[0] = 8'h3C;
    rdy[0]  = 1'b1;
    repeat (45) @(negedge clk);
    check("abort busy before reset", 32'(busy_w[0]), 32'(1));
    rst[0] = 1'b1;
    #1;
    check("abort tx/busy immediate", 32'({tx_w[0], busy_w[0]}), 32'(2'b10));
    @(negedge clk);
    rst[0] = 1'b0;
    run_frame(0, 8'h3C, 1, 1'b0, 0, 101 + 10 * PAR, "restart");

    // Reset held while ready_to_read pulses: no frame afterwards.
    begin
      int bad = 0;
      @(negedge clk);
      rst[0] = 1'b1;
      rdy[0] = 1'b0;
      @(negedge clk);
      rdy[0] = 1'b1;
      @(negedge clk);
      rdy[0] = 1'b0;
      rst[0] = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
      end
      check("trigger under reset ignored", 32'(bad), 32'(0));
    end

    // Randomized bytes against the frame model.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      apply_reset(0);
      run_frame(0, rb, 1, 1'($urandom_range(0, 1)), $urandom_range(2, 60),
                101 + 10 * PAR, $sformatf("rand%0d", r));
    end

    // Two stop bits.
    apply_reset(1);
    run_frame(1, 8'h01, 2, 1'b0, 0, 111 + 10 * PAR, "stop2");
    idle_check(1, 40, "stop2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
